// File: rtl/dragon_head_ctrl_if.sv
// Signal bundle between the game-state logic and the dragon head controller.
// The master side drives player/sheep information; the slave side (the controller) drives the head.
interface dragon_head_ctrl_if #(
  parameter int COORD_W = 4,
  parameter int LEN_W   = 4
);
  logic [2*COORD_W-1:0] player_location;
  logic [2*COORD_W-1:0] sheep_location;
  logic                 player_hit;
  logic [2*COORD_W-1:0] dragon_head_location;
  logic [1:0]           dragon_head_direction;
  logic [LEN_W-1:0]     dragon_body_length;
  logic [1:0]           dragon_state;
  logic                 move_strobe;
  logic                 sheep_eaten;

  modport master (
    output player_location, sheep_location, player_hit,
    input  dragon_head_location, dragon_head_direction, dragon_body_length,
           dragon_state, move_strobe, sheep_eaten
  );

  modport slave (
    input  player_location, sheep_location, player_hit,
    output dragon_head_location, dragon_head_direction, dragon_body_length,
           dragon_state, move_strobe, sheep_eaten
  );
endinterface

// File: rtl/dragon_head_ctrl.sv
// Dragon head controller: paced grid movement toward a state-dependent target,
// body-length bookkeeping, LFSR-driven retreat corners and scatter tiles, and a terminal DEAD state.
module dragon_head_ctrl #(
  parameter int                    COORD_W       = 4,
  parameter int                    LEN_W         = 4,
  parameter int                    MAX_LEN       = 15,
  parameter int                    INIT_LEN      = 3,
  parameter logic [2*COORD_W-1:0]  START_LOC     = 8'h88,
  parameter int                    MOVE_DIV      = 4,
  parameter int                    SCATTER_STEPS = 16,
  parameter logic [15:0]           LFSR_SEED     = 16'hACE1
) (
  input  logic               frame_clk,
  input  logic               rst,
  dragon_head_ctrl_if.slave  bus
);

  localparam int LOC_W  = 2*COORD_W;
  localparam int DIV_W  = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int SCAT_W = $clog2(SCATTER_STEPS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(MOVE_DIV - 1);
  localparam logic [SCAT_W-1:0] SCAT_LAST = SCAT_W'(SCATTER_STEPS - 1);
  localparam logic [LEN_W-1:0]  MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]  INIT_LEN_L = LEN_W'(INIT_LEN);

  typedef enum logic [1:0] {
    CONTEST = 2'd0,
    RETREAT = 2'd1,
    SCATTER = 2'd2,
    DEAD    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  state_t              state_q, state_d;
  dir_t                dir_q, dir_d;
  logic [LOC_W-1:0]    head_q, head_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DIV_W-1:0]    step_cnt_q, step_cnt_d;
  logic [SCAT_W-1:0]   scat_cnt_q, scat_cnt_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [LOC_W-1:0]    corner_q, corner_d;
  logic [LOC_W-1:0]    tile_q, tile_d;
  logic                move_strobe_q, move_strobe_d;
  logic                sheep_eaten_q, sheep_eaten_d;

  logic                tick;
  logic [15:0]         lfsr_next;
  logic [LOC_W-1:0]    corner_pick;
  logic [COORD_W-1:0]  head_x, head_y, tgt_x, tgt_y;
  logic [COORD_W-1:0]  x_inc, x_dec, y_inc, y_dec;
  logic [COORD_W:0]    dist_player, dist_sheep, adx, ady;
  logic [LOC_W-1:0]    target;
  logic                step_valid;
  logic [LOC_W-1:0]    step_loc;
  dir_t                step_dir;

  function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b);
    abs_diff = (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
  endfunction

  assign tick      = (step_cnt_q == DIV_LAST);
  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  // LFSR bit 0 picks the max x edge, bit 1 the max y edge.
  assign corner_pick = {{COORD_W{lfsr_q[0]}}, {COORD_W{lfsr_q[1]}}};

  assign head_x = head_q[LOC_W-1:COORD_W];
  assign head_y = head_q[COORD_W-1:0];
  assign x_inc  = head_x + 1'b1;
  assign x_dec  = head_x - 1'b1;
  assign y_inc  = head_y + 1'b1;
  assign y_dec  = head_y - 1'b1;

  assign dist_player = abs_diff(head_x, bus.player_location[LOC_W-1:COORD_W])
                     + abs_diff(head_y, bus.player_location[COORD_W-1:0]);
  assign dist_sheep  = abs_diff(head_x, bus.sheep_location[LOC_W-1:COORD_W])
                     + abs_diff(head_y, bus.sheep_location[COORD_W-1:0]);

  // A distance tie goes to the sheep.
  always_comb begin
    target = head_q;
    unique case (state_q)
      CONTEST: target = (dist_player < dist_sheep) ? bus.player_location : bus.sheep_location;
      RETREAT: target = corner_q;
      SCATTER: target = tile_q;
      default: target = head_q;
    endcase
  end

  assign tgt_x = target[LOC_W-1:COORD_W];
  assign tgt_y = target[COORD_W-1:0];
  assign adx   = abs_diff(tgt_x, head_x);
  assign ady   = abs_diff(tgt_y, head_y);

  // The x axis wins whenever it is at least as far off as y.
  always_comb begin
    step_valid = 1'b0;
    step_loc   = head_q;
    step_dir   = dir_q;
    if (adx >= ady && adx != '0) begin
      step_valid = 1'b1;
      if (tgt_x > head_x) begin
        step_loc = {x_inc, head_y};
        step_dir = DIR_RIGHT;
      end else begin
        step_loc = {x_dec, head_y};
        step_dir = DIR_LEFT;
      end
    end else if (ady != '0) begin
      step_valid = 1'b1;
      if (tgt_y > head_y) begin
        step_loc = {head_x, y_inc};
        step_dir = DIR_DOWN;
      end else begin
        step_loc = {head_x, y_dec};
        step_dir = DIR_UP;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    head_d        = head_q;
    len_d         = len_q;
    step_cnt_d    = step_cnt_q;
    scat_cnt_d    = scat_cnt_q;
    lfsr_d        = lfsr_q;
    corner_d      = corner_q;
    tile_d        = tile_q;
    move_strobe_d = 1'b0;
    sheep_eaten_d = 1'b0;

    if (state_q != DEAD) begin
      lfsr_d     = lfsr_next;
      step_cnt_d = tick ? '0 : step_cnt_q + 1'b1;

      if (tick && step_valid) begin
        head_d        = step_loc;
        dir_d         = step_dir;
        move_strobe_d = 1'b1;
      end

      // Transitions look at the post-move head; a hit overrides a sheep landing.
      if (bus.player_hit && (state_q == CONTEST || state_q == SCATTER)) begin
        if (len_q == '0) begin
          state_d = DEAD;
        end else begin
          len_d    = len_q - 1'b1;
          state_d  = RETREAT;
          corner_d = corner_pick;
        end
      end else if (state_q == CONTEST && tick && head_d == bus.sheep_location) begin
        sheep_eaten_d = 1'b1;
        if (len_q < MAX_LEN_L) len_d = len_q + 1'b1;
        state_d    = SCATTER;
        tile_d     = lfsr_q[LOC_W-1:0];
        scat_cnt_d = '0;
      end else if (state_q == RETREAT && head_d == corner_q) begin
        state_d = CONTEST;
      end else if (state_q == SCATTER) begin
        if (tick) scat_cnt_d = scat_cnt_q + 1'b1;
        if (head_d == tile_q || (tick && scat_cnt_q == SCAT_LAST)) state_d = CONTEST;
      end
    end
  end

  always_ff @(posedge frame_clk) begin
    if (rst) begin
      state_q       <= CONTEST;
      dir_q         <= DIR_RIGHT;
      head_q        <= START_LOC;
      len_q         <= INIT_LEN_L;
      step_cnt_q    <= '0;
      scat_cnt_q    <= '0;
      lfsr_q        <= LFSR_SEED;
      corner_q      <= '0;
      tile_q        <= '0;
      move_strobe_q <= 1'b0;
      sheep_eaten_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      head_q        <= head_d;
      len_q         <= len_d;
      step_cnt_q    <= step_cnt_d;
      scat_cnt_q    <= scat_cnt_d;
      lfsr_q        <= lfsr_d;
      corner_q      <= corner_d;
      tile_q        <= tile_d;
      move_strobe_q <= move_strobe_d;
      sheep_eaten_q <= sheep_eaten_d;
    end
  end

  assign bus.dragon_head_location  = head_q;
  assign bus.dragon_head_direction = dir_q;
  assign bus.dragon_body_length    = len_q;
  assign bus.dragon_state          = state_q;
  assign bus.move_strobe           = move_strobe_q;
  assign bus.sheep_eaten           = sheep_eaten_q;

endmodule

// File: tb/tb_dragon_head_ctrl.sv
// Scoreboard bench for dragon_head_ctrl: a behavioural model predicts every cycle's outputs,
// and each scenario task adds pointed checks of its own.
module tb_dragon_head_ctrl;

  localparam int          CW     = 4;
  localparam int          LW     = 4;
  localparam int          MAXL   = 4;
  localparam int          INITL  = 3;
  localparam logic [7:0]  START  = 8'h88;
  localparam int          MDIV   = 2;
  localparam int          SSTEPS = 2;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam int          MAXC   = (1 << CW) - 1;
  localparam int          SNAP_W = 2*CW + 2 + LW + 2 + 2;

  logic frame_clk = 1'b0;
  logic rst = 1'b1;

  dragon_head_ctrl_if #(.COORD_W(CW), .LEN_W(LW)) bus ();

  dragon_head_ctrl #(
    .COORD_W(CW), .LEN_W(LW), .MAX_LEN(MAXL), .INIT_LEN(INITL), .START_LOC(START),
    .MOVE_DIV(MDIV), .SCATTER_STEPS(SSTEPS), .LFSR_SEED(SEED)
  ) dut (
    .frame_clk(frame_clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 frame_clk = ~frame_clk;

  int checks = 0;
  int passed = 0;

  logic [SNAP_W-1:0] sb_q[$];
  logic [SNAP_W-1:0] sb_exp;

  int m_x, m_y, m_dir, m_len, m_state, m_cnt, m_scnt;
  int m_cx, m_cy, m_tx, m_ty, m_strobe, m_eaten;
  logic [15:0] m_lfsr;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [SNAP_W-1:0] dut_snap();
    return {bus.dragon_head_location, bus.dragon_head_direction, bus.dragon_body_length,
            bus.dragon_state, bus.move_strobe, bus.sheep_eaten};
  endfunction

  function automatic logic [SNAP_W-1:0] model_snap();
    return {CW'(m_x), CW'(m_y), 2'(m_dir), LW'(m_len), 2'(m_state), 1'(m_strobe), 1'(m_eaten)};
  endfunction

  // One frame_clk edge of the game rules, computed from the inputs applied this cycle.
  task automatic model_update(input logic r, input logic hit,
                              input logic [2*CW-1:0] ploc, input logic [2*CW-1:0] sloc);
    int px, py, sx, sy, tx, ty, dx, dy;
    bit tick;
    logic [15:0] cur;
    if (r) begin
      m_x = START[2*CW-1:CW]; m_y = START[CW-1:0];
      m_dir = 1; m_len = INITL; m_state = 0; m_cnt = 0; m_scnt = 0;
      m_lfsr = SEED; m_strobe = 0; m_eaten = 0;
      return;
    end
    m_strobe = 0;
    m_eaten  = 0;
    if (m_state == 3) return;
    tick  = (m_cnt == MDIV - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    cur    = m_lfsr;
    m_lfsr = {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    px = ploc[2*CW-1:CW]; py = ploc[CW-1:0];
    sx = sloc[2*CW-1:CW]; sy = sloc[CW-1:0];
    if (m_state == 0) begin
      if (iabs(px - m_x) + iabs(py - m_y) < iabs(sx - m_x) + iabs(sy - m_y)) begin
        tx = px; ty = py;
      end else begin
        tx = sx; ty = sy;
      end
    end else if (m_state == 1) begin
      tx = m_cx; ty = m_cy;
    end else begin
      tx = m_tx; ty = m_ty;
    end
    if (tick) begin
      dx = tx - m_x;
      dy = ty - m_y;
      if (dx != 0 && iabs(dx) >= iabs(dy)) begin
        m_x += (dx > 0) ? 1 : -1; m_dir = (dx > 0) ? 1 : 3; m_strobe = 1;
      end else if (dy != 0) begin
        m_y += (dy > 0) ? 1 : -1; m_dir = (dy > 0) ? 2 : 0; m_strobe = 1;
      end
    end
    if (hit && (m_state == 0 || m_state == 2)) begin
      if (m_len == 0) m_state = 3;
      else begin
        m_len--; m_state = 1;
        m_cx = cur[0] ? MAXC : 0; m_cy = cur[1] ? MAXC : 0;
      end
    end else if (m_state == 0 && tick && m_x == sx && m_y == sy) begin
      m_eaten = 1;
      if (m_len < MAXL) m_len++;
      m_state = 2; m_tx = cur[2*CW-1:CW]; m_ty = cur[CW-1:0]; m_scnt = 0;
    end else if (m_state == 1 && m_x == m_cx && m_y == m_cy) begin
      m_state = 0;
    end else if (m_state == 2) begin
      if (tick) m_scnt++;
      if ((m_x == m_tx && m_y == m_ty) || (tick && m_scnt == SSTEPS)) m_state = 0;
    end
  endtask

  // Drive one cycle, push the predicted outputs, and return at the following negedge.
  task automatic step(input logic r, input logic hit);
    rst = r;
    bus.player_hit = hit;
    model_update(r, hit, bus.player_location, bus.sheep_location);
    sb_q.push_back(model_snap());
    @(posedge frame_clk);
    @(negedge frame_clk);
    rst = 1'b0;
    bus.player_hit = 1'b0;
  endtask

  task automatic test_reset();
    bus.player_location = 8'h00;
    bus.sheep_location  = 8'h8C;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0);
      sb_exp = sb_q.pop_front(); checks++;
      if (dut_snap() !== sb_exp) $display("[TB] FAIL sb_reset: got %h expected %h", dut_snap(), sb_exp);
      else passed++;
    end
    checks++;
    if (dut_snap() !== {8'h88, 2'd1, 4'd3, 2'd0, 1'b0, 1'b0})
      $display("[TB] FAIL reset_values: got %h expected %h", dut_snap(), {8'h88, 2'd1, 4'd3, 2'd0, 2'b00});
    else passed++;
  endtask

  task automatic test_pace();
    logic [7:0] seq [4] = '{8'h89, 8'h8A, 8'h8B, 8'h8C};
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 2; c++) begin
        step(1'b0, 1'b0);
        sb_exp = sb_q.pop_front(); checks++;
        if (dut_snap() !== sb_exp) $display("[TB] FAIL sb_pace: got %h expected %h", dut_snap(), sb_exp);
        else passed++;
      end
      checks++;
      if (bus.move_strobe !== 1'b1 || bus.dragon_head_location !== seq[k] || bus.dragon_head_direction !== 2'd2)
        $display("[TB] FAIL pace_step: got head %h dir %0d strobe %b expected head %h dir 2 strobe 1",
                 bus.dragon_head_location, bus.dragon_head_direction, bus.move_strobe, seq[k]);
      else passed++;
    end
    checks++;
    if (bus.sheep_eaten !== 1'b1 || bus.dragon_body_length !== 4'd4 || bus.dragon_state !== 2'd2)
      $display("[TB] FAIL pace_eat: got eaten %b len %0d state %0d expected eaten 1 len 4 state 2",
               bus.sheep_eaten, bus.dragon_body_length, bus.dragon_state);
    else passed++;
  endtask

  task automatic test_scatter_timeout();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0);
      sb_exp = sb_q.pop_front(); checks++;
      if (dut_snap() !== sb_exp) $display("[TB] FAIL sb_scatter: got %h expected %h", dut_snap(), sb_exp);
      else passed++;
      if (i == 2) begin
        checks++;
        if (bus.dragon_state !== 2'd2)
          $display("[TB] FAIL scatter_hold: got state %0d expected 2", bus.dragon_state);
        else passed++;
      end
    end
    checks++;
    if (bus.dragon_state !== 2'd0 || bus.dragon_head_location !== 8'h8A)
      $display("[TB] FAIL scatter_timeout: got state %0d head %h expected state 0 head 8a",
               bus.dragon_state, bus.dragon_head_location);
    else passed++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20 && m_eaten == 0; i++) begin
      step(1'b0, 1'b0);
      sb_exp = sb_q.pop_front(); checks++;
      if (dut_snap() !== sb_exp) $display("[TB] FAIL sb_saturate: got %h expected %h", dut_snap(), sb_exp);
      else passed++;
    end
    checks++;
    if (bus.sheep_eaten !== 1'b1 || bus.dragon_body_length !== 4'd4 || bus.dragon_state !== 2'd2)
      $display("[TB] FAIL saturate: got eaten %b len %0d state %0d expected eaten 1 len 4 state 2",
               bus.sheep_eaten, bus.dragon_body_length, bus.dragon_state);
    else passed++;
  endtask

  task automatic test_hit_retreat();
    logic [7:0] h;
    for (int i = 0; i < 20 && m_state != 0; i++) begin
      step(1'b0, 1'b0);
      sb_exp = sb_q.pop_front(); checks++;
      if (dut_snap() !== sb_exp) $display("[TB] FAIL sb_retreat: got %h expected %h", dut_snap(), sb_exp);
      else passed++;
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1);
      sb_exp = sb_q.pop_front(); checks++;
      if (dut_snap() !== sb_exp) $display("[TB] FAIL sb_retreat: got %h expected %h", dut_snap(), sb_exp);
      else passed++;
      checks++;
      if (bus.dragon_body_length !== 4'd3 || bus.dragon_state !== 2'd1)
        $display("[TB] FAIL hit_retreat: got len %0d state %0d expected len 3 state 1",
                 bus.dragon_body_length, bus.dragon_state);
      else passed++;
    end
    for (int i = 0; i < 200 && m_state != 0; i++) begin
      step(1'b0, 1'b0);
      sb_exp = sb_q.pop_front(); checks++;
      if (dut_snap() !== sb_exp) $display("[TB] FAIL sb_retreat: got %h expected %h", dut_snap(), sb_exp);
      else passed++;
    end
    h = bus.dragon_head_location;
    checks++;
    if (bus.dragon_state !== 2'd0 || !(h == 8'h00 || h == 8'hF0 || h == 8'h0F || h == 8'hFF))
      $display("[TB] FAIL retreat_corner: got state %0d head %h expected state 0 at a corner",
               bus.dragon_state, h);
    else passed++;
  endtask

  task automatic test_tie();
    bus.player_location = 8'h8A;
    bus.sheep_location  = 8'hA8;
    for (int i = 0; i < 4; i++) begin
      step(i < 2, 1'b0);
      sb_exp = sb_q.pop_front(); checks++;
      if (dut_snap() !== sb_exp) $display("[TB] FAIL sb_tie: got %h expected %h", dut_snap(), sb_exp);
      else passed++;
    end
    checks++;
    if (bus.dragon_head_location !== 8'h98 || bus.dragon_head_direction !== 2'd1)
      $display("[TB] FAIL tie_to_sheep: got head %h dir %0d expected head 98 dir 1",
               bus.dragon_head_location, bus.dragon_head_direction);
    else passed++;
    bus.player_location = 8'h99;
    bus.sheep_location  = 8'h9B;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0);
      sb_exp = sb_q.pop_front(); checks++;
      if (dut_snap() !== sb_exp) $display("[TB] FAIL sb_tie: got %h expected %h", dut_snap(), sb_exp);
      else passed++;
    end
    checks++;
    if (bus.dragon_head_location !== 8'h99 || bus.dragon_head_direction !== 2'd2)
      $display("[TB] FAIL closer_player: got head %h dir %0d expected head 99 dir 2",
               bus.dragon_head_location, bus.dragon_head_direction);
    else passed++;
  endtask

  task automatic test_hit_eat();
    bus.player_location = 8'h00;
    bus.sheep_location  = 8'h8C;
    for (int i = 0; i < 10; i++) begin
      step(i < 2, i == 9);
      sb_exp = sb_q.pop_front(); checks++;
      if (dut_snap() !== sb_exp) $display("[TB] FAIL sb_hit_eat: got %h expected %h", dut_snap(), sb_exp);
      else passed++;
    end
    checks++;
    if (dut_snap() !== {8'h8C, 2'd2, 4'd2, 2'd1, 1'b1, 1'b0})
      $display("[TB] FAIL hit_beats_eat: got %h expected %h", dut_snap(), {8'h8C, 2'd2, 4'd2, 2'd1, 2'b10});
    else passed++;
  endtask

  task automatic test_death();
    for (int i = 0; i < 600 && m_state != 3; i++) begin
      step(1'b0, m_state == 0 || m_state == 2);
      sb_exp = sb_q.pop_front(); checks++;
      if (dut_snap() !== sb_exp) $display("[TB] FAIL sb_death: got %h expected %h", dut_snap(), sb_exp);
      else passed++;
    end
    checks++;
    if (m_state != 3 || bus.dragon_state !== 2'd3 || bus.dragon_body_length !== 4'd0)
      $display("[TB] FAIL death_entry: got state %0d len %0d expected state 3 len 0",
               bus.dragon_state, bus.dragon_body_length);
    else passed++;
    for (int i = 0; i < 100; i++) begin
      bus.player_location = 8'(i * 7);
      bus.sheep_location  = 8'(i * 13);
      step(1'b0, i[0]);
      sb_exp = sb_q.pop_front(); checks++;
      if (dut_snap() !== sb_exp) $display("[TB] FAIL sb_dead_hold: got %h expected %h", dut_snap(), sb_exp);
      else passed++;
      checks++;
      if (bus.move_strobe !== 1'b0 || bus.sheep_eaten !== 1'b0 || bus.dragon_state !== 2'd3)
        $display("[TB] FAIL dead_strobes: got strobe %b eaten %b state %0d expected 0 0 3",
                 bus.move_strobe, bus.sheep_eaten, bus.dragon_state);
      else passed++;
    end
    step(1'b1, 1'b0);
    sb_exp = sb_q.pop_front(); checks++;
    if (dut_snap() !== sb_exp) $display("[TB] FAIL sb_dead_reset: got %h expected %h", dut_snap(), sb_exp);
    else passed++;
    checks++;
    if (dut_snap() !== {8'h88, 2'd1, 4'd3, 2'd0, 1'b0, 1'b0})
      $display("[TB] FAIL dead_reset: got %h expected %h", dut_snap(), {8'h88, 2'd1, 4'd3, 2'd0, 2'b00});
    else passed++;
  endtask

  initial begin
    bus.player_location = 8'h00;
    bus.sheep_location  = 8'h8C;
    bus.player_hit      = 1'b0;
    @(negedge frame_clk);
    $display("[TB] starting dragon_head_ctrl scenarios");
    test_reset();
    test_pace();
    test_scatter_timeout();
    test_saturation();
    test_hit_retreat();
    test_tie();
    test_hit_eat();
    test_death();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
